mm_step_sequencer: RTL

//   Upstream controller for the per-step microsecond throttle. Accepts one

---
 rtl/mm_step_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mm_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_step_sequencer
// Brief    : Runs one move command as on/off throttle phases per motor step.
// Revision : 1.0 - initial release
// ============================================================================
module mm_step_sequencer #(
  parameter int REG_W = 16
) (
  input  logic             clock_16mhz,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_dir,
  input  logic [REG_W-1:0] i_cmd_steps,
  input  logic [REG_W-1:0] i_cmd_on_us,
  input  logic [REG_W-1:0] i_cmd_off_us,
  input  logic             i_abort,
  output logic             o_throttle_load,
  output logic [REG_W-1:0] o_throttle_len,
  input  logic             i_throttle_done,
  output logic             o_motor_step,
  output logic             o_motor_dir,
  output logic             o_busy,
  output logic [REG_W-1:0] o_steps_taken,
  output logic             o_move_done,
  output logic             o_aborted
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_ON  = 3'd1,
    S_ARM_ON   = 3'd2,
    S_PULSE    = 3'd3,
    S_LOAD_OFF = 3'd4,
    S_ARM_OFF  = 3'd5,
    S_REST     = 3'd6,
    S_FINISH   = 3'd7
  } state_t;

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_dir;
  logic [REG_W-1:0] r_steps;
  logic [REG_W-1:0] r_on_us;
  logic [REG_W-1:0] r_off_us;
  logic [REG_W-1:0] r_steps_taken;
  logic             r_aborted;
  logic             r_busy;
  logic             r_motor_step;
  logic             r_load;
  logic [REG_W-1:0] r_len;
  logic             r_move_done;

  state_t           w_next;
  logic             w_accept;
  logic             w_step_inc;
  logic             w_abort_hit;
  logic [REG_W-1:0] w_on_us;

  always_comb begin
    w_next      = r_state;
    w_step_inc  = 1'b0;
    w_abort_hit = 1'b0;
    w_accept    = (r_state == S_IDLE) && i_cmd_valid && r_cmd_ready;
    // The on-time for the first LOAD_ON comes straight from the command bus.
    w_on_us     = w_accept ? i_cmd_on_us : r_on_us;
    if (i_abort && (r_state != S_IDLE) && (r_state != S_FINISH)) begin
      w_next      = S_FINISH;
      w_abort_hit = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_next = (i_cmd_steps == '0) ? S_FINISH : S_LOAD_ON;
          end
        end
        S_LOAD_ON:  w_next = S_ARM_ON;
        S_ARM_ON:   w_next = S_PULSE;
        S_PULSE: begin
          if (i_throttle_done) begin
            w_step_inc = 1'b1;
            w_next     = S_LOAD_OFF;
          end
        end
        S_LOAD_OFF: w_next = S_ARM_OFF;
        S_ARM_OFF:  w_next = S_REST;
        S_REST: begin
          if (i_throttle_done) begin
            w_next = (r_steps_taken == r_steps) ? S_FINISH : S_LOAD_ON;
          end
        end
        S_FINISH:   w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock_16mhz or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_dir         <= 1'b0;
      r_steps       <= '0;
      r_on_us       <= '0;
      r_off_us      <= '0;
      r_steps_taken <= '0;
      r_aborted     <= 1'b0;
      r_busy        <= 1'b0;
      r_motor_step  <= 1'b0;
      r_load        <= 1'b0;
      r_len         <= '0;
      r_move_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir         <= i_cmd_dir;
        r_steps       <= i_cmd_steps;
        r_on_us       <= i_cmd_on_us;
        r_off_us      <= i_cmd_off_us;
        r_steps_taken <= '0;
        r_aborted     <= 1'b0;
      end else begin
        if (w_step_inc) begin
          r_steps_taken <= r_steps_taken + REG_W'(1);
        end
        if (w_abort_hit) begin
          r_aborted <= 1'b1;
        end
      end
      r_cmd_ready  <= (w_next == S_IDLE);
      r_busy       <= (w_next != S_IDLE);
      r_motor_step <= (w_next == S_LOAD_ON) || (w_next == S_ARM_ON) ||
                      (w_next == S_PULSE);
      r_load       <= (w_next == S_LOAD_ON) || (w_next == S_LOAD_OFF);
      r_move_done  <= (w_next == S_FINISH);
      if (w_next == S_LOAD_ON) begin
        r_len <= w_on_us;
      end else if (w_next == S_LOAD_OFF) begin
        r_len <= r_off_us;
      end else begin
        r_len <= '0;
      end
    end
  end

  assign o_cmd_ready     = r_cmd_ready;
  assign o_throttle_load = r_load;
  assign o_throttle_len  = r_len;
  assign o_motor_step    = r_motor_step;
  assign o_motor_dir     = r_dir;
  assign o_busy          = r_busy;
  assign o_steps_taken   = r_steps_taken;
  assign o_move_done     = r_move_done;
  assign o_aborted       = r_aborted;

endmodule
`default_nettype wire
